tdm_mux8: RTL and testbench

TDM_MUX8 -- requirements
Module: tdm_mux8

---
 rtl/tdm_mux8_pkg.sv | 9 +
 rtl/tdm_mux8_if.sv | 14 +
 rtl/tdm_slot_counter.sv | 29 ++
 rtl/tdm_mux8.sv | 50 +++++
 tb/tb_tdm_mux8.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tdm_mux8_pkg.sv
// tdm_mux8_pkg: shared channel geometry and state encoding for the TDM mux/demux pair
package tdm_mux8_pkg;
    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic slot_bit(input logic [NUM_CH-1:0] d, m, input logic [SLOT_W-1:0] s);
        return d[s] & m[s];
    endfunction
endpackage

// File: rtl/tdm_mux8_if.sv
// tdm_mux8_if: parallel-in / serial-out TDM bus between the mux and its demux side
interface tdm_mux8_if;
    import tdm_mux8_pkg::*;
    logic en;
    logic [NUM_CH-1:0] D;
    logic [NUM_CH-1:0] ch_mask;
    logic I;
    logic [SLOT_W-1:0] S;
    logic valid;
    logic frame_start;
    logic busy;
    modport master (input en, D, ch_mask, output I, S, valid, frame_start, busy);
    modport slave (output en, D, ch_mask, input I, S, valid, frame_start, busy);
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: holds each slot SLOT_CYCLES cycles and steps the slot index
module tdm_slot_counter import tdm_mux8_pkg::*; #(
    parameter int SLOT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [SLOT_W-1:0] S,
    output logic              slot_last,
    output logic              frame_last
);
    localparam int CNT_W = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt;
    // terminal-count decode of the cycle counter and the slot index
    always_comb begin
        slot_last = cnt == CNT_W'(SLOT_CYCLES - 1);
        frame_last = slot_last && S == SLOT_W'(NUM_CH - 1);
    end
    // counter sits at zero when not advancing; slot index wraps 7 -> 0 on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            S <= '0;
        end else begin
            cnt <= adv && !slot_last ? cnt + 1'b1 : '0;
            S <= adv && slot_last ? S + 1'b1 : S;
        end
    end
endmodule

// File: rtl/tdm_mux8.sv
// tdm_mux8: 8-channel time-division multiplexer with per-frame snapshot and channel mask
module tdm_mux8 import tdm_mux8_pkg::*; #(
    parameter int SLOT_CYCLES = 1
) (
    input logic         clk,
    input logic         rst,
    tdm_mux8_if.master  bus
);
    state_t state, state_nxt;
    logic [NUM_CH-1:0] snap_d, snap_m, d_nxt, m_nxt;
    logic [SLOT_W-1:0] s, s_nxt;
    logic slot_last, frame_last, take;
    tdm_slot_counter #(.SLOT_CYCLES(SLOT_CYCLES)) u_cnt (
        .clk(clk),
        .rst(rst),
        .adv(state == RUN),
        .S(s),
        .slot_last(slot_last),
        .frame_last(frame_last)
    );
    assign bus.S = s;
    // a new snapshot is taken from IDLE or back-to-back at the end of a frame
    always_comb begin
        take = bus.en && (state == IDLE || frame_last);
        state_nxt = take ? RUN : frame_last ? IDLE : state;
        d_nxt = take ? bus.D : snap_d;
        m_nxt = take ? bus.ch_mask : snap_m;
        s_nxt = state == RUN && slot_last ? s + 1'b1 : s;
    end
    // outputs are registered from next-state values so I/valid line up with S
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            snap_d <= '0;
            snap_m <= '0;
            bus.I <= 1'b0;
            bus.valid <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state <= state_nxt;
            snap_d <= d_nxt;
            snap_m <= m_nxt;
            bus.I <= state_nxt == RUN && slot_bit(d_nxt, m_nxt, s_nxt);
            bus.valid <= state_nxt == RUN && m_nxt[s_nxt];
            bus.frame_start <= take;
            bus.busy <= state_nxt == RUN;
        end
    end
endmodule

// File: tb/tb_tdm_mux8.sv
// tb_tdm_mux8: scoreboard bench running SLOT_CYCLES=1 and SLOT_CYCLES=3 instances side by side
module tb_tdm_mux8;
    import tdm_mux8_pkg::*;
    typedef struct packed {
        logic [SLOT_W-1:0] s;
        logic i;
        logic v;
        logic fs;
        logic busy;
    } rec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] m = 8'h00;
    int total = 0;
    int bad = 0;
    rec_t act [2];
    rec_t sb [2][$];
    rec_t pend [2][$];
    rec_t exp_r;
    tdm_mux8_if b1 ();
    tdm_mux8_if b3 ();
    assign b1.en = en;
    assign b1.D = d;
    assign b1.ch_mask = m;
    assign b3.en = en;
    assign b3.D = d;
    assign b3.ch_mask = m;
    tdm_mux8 #(.SLOT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    tdm_mux8 #(.SLOT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    assign act[0] = {b1.S, b1.I, b1.valid, b1.frame_start, b1.busy};
    assign act[1] = {b3.S, b3.I, b3.valid, b3.frame_start, b3.busy};
    always #5 clk = ~clk;

    function automatic int sc(input int j);
        return j != 0 ? 3 : 1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endfunction

    // frame-level reference: with no frame pending, en at an edge queues a whole new frame
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                sb[j].delete();
                pend[j].delete();
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (en && pend[j].size() == 0)
                    for (int k = 0; k < 8; k++)
                        for (int c = 0; c < sc(j); c++)
                            pend[j].push_back({3'(k), d[k] & m[k], m[k], k == 0 && c == 0, 1'b1});
                if (pend[j].size() != 0) sb[j].push_back(pend[j].pop_front());
                else sb[j].push_back(rec_t'(0));
            end
        end
    end

    // monitor: every cycle out of reset, each DUT's outputs must match the queued record
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                if (sb[j].size() == 0) chk($sformatf("sb_empty%0d", j), 0, 1);
                else begin
                    exp_r = sb[j].pop_front();
                    chk($sformatf("out%0d", j), act[j], exp_r);
                end
            end
        end
    end

    task automatic waitfs(input int j, output int ok);
        ok = 0;
        for (int n = 0; n < 64 && ok == 0; n++) begin
            @(negedge clk);
            ok = int'(act[j].fs);
        end
    endtask

    task automatic grab(input int j, input int poke, output logic [7:0] iv, output logic [7:0] vv, output int ok);
        iv = 8'h00;
        vv = 8'h00;
        waitfs(j, ok);
        for (int c = 0; c < 8 * sc(j); c++) begin
            if (c != 0) @(negedge clk);
            if (c == poke) d = 8'h00;
            iv[act[j].s] = act[j].i;
            vv[act[j].s] = act[j].v;
        end
    endtask

    initial begin
        logic [7:0] iv, vv;
        int ok, n;
        #2 rst = 1'b1;
        #1;
        chk("rst_out1", act[0], 0);
        chk("rst_out3", act[1], 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_out1", act[0], 0);
        en = 1'b1; d = 8'hA6; m = 8'hFF;
        grab(0, -1, iv, vv, ok);
        chk("a_found", ok, 1);
        chk("a_I", iv, 8'hA6);
        chk("a_valid", vv, 8'hFF);
        @(negedge clk);
        chk("a_no_gap_fs", b1.frame_start, 1);
        d = 8'hFF; m = 8'hF0;
        grab(0, -1, iv, vv, ok);
        chk("b_found", ok, 1);
        chk("b_I", iv, 8'hF0);
        chk("b_valid", vv, 8'hF0);
        d = 8'hA6; m = 8'hFF;
        grab(1, 5, iv, vv, ok);
        chk("c_found", ok, 1);
        chk("c_I_held", iv, 8'hA6);
        chk("c_valid", vv, 8'hFF);
        grab(1, -1, iv, vv, ok);
        chk("c_next_found", ok, 1);
        chk("c_next_I", iv, 8'h00);
        d = 8'h3C;
        waitfs(0, ok);
        chk("d_found", ok, 1);
        repeat (2) @(negedge clk);
        chk("d_slot2", b1.S, 2);
        en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b1.busy && n < 20);
        chk("d_len", n, 6);
        chk("d_s_idle", b1.S, 0);
        repeat (30) @(negedge clk);
        chk("d_idle3", b3.busy, 0);
        en = 1'b1; d = 8'h5A; m = 8'hFF;
        waitfs(0, ok);
        chk("e_found", ok, 1);
        repeat (5) @(negedge clk);
        chk("e_slot5", b1.S, 5);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("e_rst_out1", act[0], 0);
        chk("e_rst_out3", act[1], 0);
        @(negedge clk);
        #1 rst = 1'b0;
        waitfs(0, ok);
        chk("e_restart", ok, 1);
        chk("e_restart_s", b1.S, 0);
        grab(0, -1, iv, vv, ok);
        chk("f_found", ok, 1);
        chk("f_demux", iv, 8'h5A);
        en = 1'b0;
        repeat (40) @(negedge clk);
        chk("end_idle1", act[0], 0);
        chk("end_idle3", act[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
